// File: rtl/stopwatch_control_if.sv
// Button/status bundle between the debouncers, the stopwatch control FSM and
// the counter/display datapath.
// The master side drives button levels and at_max; the slave side is the controller.
interface stopwatch_control_if;
    logic       start_btn;
    logic       stop_btn;
    logic       reset_btn;
    logic       lap_btn;
    logic       at_max;
    logic       count_en;
    logic       clear;
    logic       running;
    logic       hold;
    logic       latch;
    logic [1:0] state;

    modport master (
        output start_btn, stop_btn, reset_btn, lap_btn, at_max,
        input  count_en, clear, running, hold, latch, state
    );

    modport slave (
        input  start_btn, stop_btn, reset_btn, lap_btn, at_max,
        output count_en, clear, running, hold, latch, state
    );
endinterface

// File: rtl/stopwatch_control.sv
// Stopwatch control FSM.
// Turns debounced button levels into run/pause/clear sequencing and divides clk
// into one-cycle count ticks for the seconds counter. It also handles lap-hold
// of the display and stops counting at the terminal value.
module stopwatch_control #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stopwatch_control_if.slave   bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        MAXED  = 2'd3
    } state_t;

    // Button order inside the vectors: {lap, start, stop, reset}.
    logic [3:0]    btn;
    logic [3:0]    btn_prev_reg;
    logic [3:0]    press;

    state_t        state_reg, state_next;
    logic [PW-1:0] psc_reg, psc_next;
    logic          hold_reg, hold_next;
    logic          count_en_reg, count_en_next;
    logic          clear_reg, clear_next;
    logic          latch_reg, latch_next;
    logic          running_reg, running_next;

    logic          press_reset, press_stop, press_start, press_lap;

    assign btn         = {bus.lap_btn, bus.start_btn, bus.stop_btn, bus.reset_btn};
    assign press       = btn & ~btn_prev_reg;
    assign press_reset = press[0];
    assign press_stop  = press[1];
    assign press_start = press[2];
    assign press_lap   = press[3];

    // Previous-sample registers. They load 1 in reset, so a button held through
    // reset does not count as a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev_reg <= 4'b1111;
        end else begin
            btn_prev_reg <= btn;
        end
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            psc_reg      <= '0;
            hold_reg     <= 1'b0;
            count_en_reg <= 1'b0;
            clear_reg    <= 1'b0;
            latch_reg    <= 1'b0;
            running_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            psc_reg      <= psc_next;
            hold_reg     <= hold_next;
            count_en_reg <= count_en_next;
            clear_reg    <= clear_next;
            latch_reg    <= latch_next;
            running_reg  <= running_next;
        end
    end

    // Next-state logic. Only the highest-priority legal press is acted on
    // (reset > stop > start > lap). RUN keeps counting unless stop or reset wins.
    always_comb begin
        state_next    = state_reg;
        psc_next      = psc_reg;
        hold_next     = hold_reg;
        count_en_next = 1'b0;
        clear_next    = 1'b0;
        latch_next    = 1'b0;

        if (press_reset) begin
            state_next = IDLE;
            psc_next   = '0;
            hold_next  = 1'b0;
            clear_next = 1'b1;
        end else if (press_stop && state_reg == RUN) begin
            // Stop wins even on the wrap edge: the prescaler stays put, so a
            // pause at TICK_DIV-1 ticks on the first edge after resuming.
            state_next = PAUSED;
        end else if (press_start && (state_reg == IDLE || state_reg == PAUSED)) begin
            state_next = RUN;
            if (state_reg == IDLE) begin
                psc_next = '0;
            end
        end else begin
            if (press_lap && state_reg != IDLE) begin
                hold_next  = ~hold_reg;
                latch_next = ~hold_reg;
            end
            if (state_reg == RUN) begin
                if (psc_reg == PSC_LAST) begin
                    psc_next = '0;
                    if (bus.at_max) begin
                        state_next = MAXED;
                    end else begin
                        count_en_next = 1'b1;
                    end
                end else begin
                    psc_next = psc_reg + 1'b1;
                end
            end
        end

        running_next = (state_next == RUN);
    end

    assign bus.count_en = count_en_reg;
    assign bus.clear    = clear_reg;
    assign bus.running  = running_reg;
    assign bus.hold     = hold_reg;
    assign bus.latch    = latch_reg;
    assign bus.state    = state_reg;
endmodule
